// File: rtl/dram_port_arbiter_if.sv
// rtl/dram_port_arbiter_if.sv - two-requester / one-DRAM-slave bus bundle for dram_port_arbiter
// slave modport is the arbiter's view; master modport is the surrounding requesters and DRAM.
interface dram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              m0_req;
    logic [DW/8-1:0]   m0_we;
    logic [AW-1:0]     m0_addr;
    logic [DW-1:0]     m0_wdata;
    logic              m0_ack;
    logic              m0_rvalid;
    logic [DW-1:0]     m0_rdata;

    logic              m1_req;
    logic [DW/8-1:0]   m1_we;
    logic [AW-1:0]     m1_addr;
    logic [DW-1:0]     m1_wdata;
    logic              m1_ack;
    logic              m1_rvalid;
    logic [DW-1:0]     m1_rdata;

    logic              s_req;
    logic [DW/8-1:0]   s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic              s_ready;
    logic              s_rvalid;
    logic [DW-1:0]     s_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rvalid, m1_rdata,
        output s_req, s_we, s_addr, s_wdata,
        input  s_ready, s_rvalid, s_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rvalid, m1_rdata,
        input  s_req, s_we, s_addr, s_wdata,
        output s_ready, s_rvalid, s_rdata
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin arbiter sharing one DRAM port between two requesters
// One transaction in flight; a watchdog turns an unanswered read into BAD_DATA plus a sticky err.
module dram_port_arbiter #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              TIMEOUT  = 1024,
    parameter logic [DW-1:0]   BAD_DATA = 32'hDEADDEAD
) (
    input  logic               CLK,
    input  logic               RST_X,
    dram_port_arbiter_if.slave bus,
    output logic               err,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q,  last_d;
    logic [15:0]     cnt_q,   cnt_d;
    logic            err_q,   err_d;

    logic            req_g;
    logic [DW/8-1:0] we_g;
    logic [AW-1:0]   addr_g;
    logic [DW-1:0]   wdata_g;
    logic            issue;
    logic            accept;
    logic            rd_hit;
    logic            rd_to;
    logic            rvalid_g;
    logic [DW-1:0]   rdata_g;

    // Granted master's live request fields; the slave sees them only while in ISSUE.
    always_comb begin
        req_g   = grant_q ? bus.m1_req   : bus.m0_req;
        we_g    = grant_q ? bus.m1_we    : bus.m0_we;
        addr_g  = grant_q ? bus.m1_addr  : bus.m0_addr;
        wdata_g = grant_q ? bus.m1_wdata : bus.m0_wdata;
    end

    always_comb begin
        issue    = (state_q == ISSUE);
        accept   = issue && req_g && bus.s_ready;
        rd_hit   = (state_q == WAIT_RD) && bus.s_rvalid;
        rd_to    = (state_q == WAIT_RD) && !bus.s_rvalid && (cnt_q == TO_LAST);
        rvalid_g = rd_hit || rd_to;
        rdata_g  = rd_hit ? bus.s_rdata : BAD_DATA;
    end

    always_comb begin
        bus.s_req     = issue;
        bus.s_we      = issue ? we_g    : '0;
        bus.s_addr    = issue ? addr_g  : '0;
        bus.s_wdata   = issue ? wdata_g : '0;

        bus.m0_ack    = accept && !grant_q;
        bus.m1_ack    = accept &&  grant_q;
        bus.m0_rvalid = rvalid_g && !grant_q;
        bus.m1_rvalid = rvalid_g &&  grant_q;
        bus.m0_rdata  = (rvalid_g && !grant_q) ? rdata_g : '0;
        bus.m1_rdata  = (rvalid_g &&  grant_q) ? rdata_g : '0;

        err           = err_q;
        busy          = (state_q != IDLE);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // Contention goes to whoever was not served last.
                    grant_d = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!req_g) begin
                    state_d = IDLE;
                end else if (bus.s_ready) begin
                    last_d = grant_q;
                    if (we_g != '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RD;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.s_rvalid) begin
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read data nobody is waiting for points at a confused controller.
        if (bus.s_rvalid && (state_q != WAIT_RD)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - scoreboard bench for dram_port_arbiter
module tb_dram_port_arbiter;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          TO  = 8;
    localparam logic [31:0] BAD = 32'hDEADDEAD;

    logic CLK   = 1'b0;
    logic RST_X = 1'b0;
    logic err;
    logic busy;

    dram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dram_port_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .TIMEOUT  (TO),
        .BAD_DATA (BAD)
    ) dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .bus   (bus.slave),
        .err   (err),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } ack_t;

    typedef struct {
        int          m;
        logic [31:0] data;
    } rd_t;

    ack_t exp_ack[$];
    rd_t  exp_rd[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ack(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        ack_t e;
        e.m = m; e.addr = a; e.wdata = d; e.we = we;
        exp_ack.push_back(e);
    endtask

    task automatic push_rd(input int m, input logic [31:0] d);
        rd_t e;
        e.m = m; e.data = d;
        exp_rd.push_back(e);
    endtask

    // Monitor: compares every ack / rvalid the DUT presents against the queues.
    initial begin
        forever begin
            ack_t ea;
            rd_t  er;
            @(negedge CLK);
            if (bus.m0_ack || bus.m1_ack) begin
                chk("ack_onehot", 64'(bus.m0_ack & bus.m1_ack), 64'd0);
                if (exp_ack.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b addr=%h, none required", bus.m0_ack, bus.m1_ack, bus.s_addr);
                end else begin
                    ea = exp_ack.pop_front();
                    chk("ack_master", bus.m1_ack ? 64'd1 : 64'd0, 64'(ea.m));
                    chk("ack_addr", 64'(bus.s_addr), 64'(ea.addr));
                    chk("ack_we", 64'(bus.s_we), 64'(ea.we));
                    if (ea.we != 4'd0) chk("ack_wdata", 64'(bus.s_wdata), 64'(ea.wdata));
                end
            end
            if (bus.m0_rvalid || bus.m1_rvalid) begin
                chk("rvalid_onehot", 64'(bus.m0_rvalid & bus.m1_rvalid), 64'd0);
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: m0_rvalid=%b m1_rvalid=%b, none required", bus.m0_rvalid, bus.m1_rvalid);
                end else begin
                    er = exp_rd.pop_front();
                    chk("rvalid_master", bus.m1_rvalid ? 64'd1 : 64'd0, 64'(er.m));
                    chk("rdata", 64'(bus.m1_rvalid ? bus.m1_rdata : bus.m0_rdata), 64'(er.data));
                    chk("rdata_other_zero", 64'(bus.m1_rvalid ? bus.m0_rdata : bus.m1_rdata), 64'd0);
                end
            end
        end
    end

    task automatic raise(input int m, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_req = 1'b1;
        end else begin
            bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_req = 1'b1;
        end
    endtask

    // Returns the number of negedges until ack was seen; drops req one cycle later.
    task automatic wait_ack_drop(input int m, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge CLK);
            n++;
            seen = (m == 0) ? bus.m0_ack : bus.m1_ack;
        end
        chk("ack_arrived", 64'(seen), 64'd1);
        @(posedge CLK); #1;
        if (m == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
    endtask

    task automatic do_write(input int m, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        int n;
        raise(m, we, a, d);
        wait_ack_drop(m, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0, n1, k;
        logic seen;

        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        bus.s_ready = 0; bus.s_rvalid = 0; bus.s_rdata = 0;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_s_req", 64'(bus.s_req), 64'd0);
        chk("rst_s_addr", 64'(bus.s_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_acks", 64'({bus.m0_ack, bus.m1_ack, bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        #3 RST_X = 1'b1;

        // Single M1 write: ack in cycle 2, idle again in cycle 3.
        @(posedge CLK); #1;
        bus.s_ready = 1'b1;
        push_ack(1, 32'h100, 32'h12345678, 4'hF);
        raise(1, 4'hF, 32'h100, 32'h12345678);
        wait_ack_drop(1, n);
        chk("t1_ack_cycle", 64'(n), 64'd2);
        @(negedge CLK);
        chk("t1_busy_low", 64'(busy), 64'd0);
        chk("t1_err", 64'(err), 64'd0);

        // Both masters requesting continuously: grants alternate starting with M0.
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) begin
            push_ack(0, 32'h200 + 32'(i * 4), 32'(i), 4'hF);
            push_ack(1, 32'h300 + 32'(i * 4), 32'(i + 16), 4'hF);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) do_write(0, 4'hF, 32'h200 + 32'(i * 4), 32'(i));
            end
            begin
                for (int j = 0; j < 4; j++) do_write(1, 4'hF, 32'h300 + 32'(j * 4), 32'(j + 16));
            end
        join

        // M0 read answered in the 5th cycle after acceptance.
        @(posedge CLK); #1;
        push_ack(0, 32'h40, 32'h0, 4'h0);
        push_rd(0, 32'hCAFEF00D);
        raise(0, 4'h0, 32'h40, 32'h0);
        wait_ack_drop(0, n);
        repeat (4) @(posedge CLK);
        #1;
        bus.s_rvalid = 1'b1; bus.s_rdata = 32'hCAFEF00D;
        @(posedge CLK); #1;
        bus.s_rvalid = 1'b0; bus.s_rdata = 32'h0;
        @(negedge CLK);
        chk("t3_err", 64'(err), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);

        // Unanswered M1 read times out in the 8th WAIT_RD cycle.
        @(posedge CLK); #1;
        push_ack(1, 32'h80, 32'h0, 4'h0);
        push_rd(1, BAD);
        raise(1, 4'h0, 32'h80, 32'h0);
        wait_ack_drop(1, n);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge CLK);
            k++;
            seen = bus.m1_rvalid;
        end
        chk("t4_timeout_cycle", 64'(k), 64'd8);
        @(negedge CLK);
        chk("t4_err_set", 64'(err), 64'd1);
        @(posedge CLK); #1;
        bus.s_rvalid = 1'b1; bus.s_rdata = 32'h1234;
        @(posedge CLK); #1;
        bus.s_rvalid = 1'b0;
        @(negedge CLK);
        chk("t4_err_sticky", 64'(err), 64'd1);

        // Backpressure: M0 write stalls 10 cycles, pending M1 must wait.
        @(posedge CLK); #1;
        bus.s_ready = 1'b0;
        push_ack(0, 32'h500, 32'hAABBCCDD, 4'h3);
        push_ack(1, 32'h600, 32'h11223344, 4'hF);
        raise(0, 4'h3, 32'h500, 32'hAABBCCDD);
        @(posedge CLK); #1;
        raise(1, 4'hF, 32'h600, 32'h11223344);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("t5_s_req", 64'(bus.s_req), 64'd1);
            chk("t5_s_addr", 64'(bus.s_addr), 64'h500);
            chk("t5_no_ack", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
        end
        @(posedge CLK); #1;
        bus.s_ready = 1'b1;
        fork
            wait_ack_drop(0, n0);
            wait_ack_drop(1, n1);
        join
        chk("t5_m0_ack_cycle", 64'(n0), 64'd1);
        chk("t5_m1_ack_cycle", 64'(n1), 64'd3);

        // Reset in the middle of a read: outputs clear at once, late data flags err.
        @(posedge CLK); #1;
        push_ack(0, 32'h700, 32'h0, 4'h0);
        raise(0, 4'h0, 32'h700, 32'h0);
        wait_ack_drop(0, n);
        @(posedge CLK); #1;
        chk("t6_busy_before", 64'(busy), 64'd1);
        bus.s_rvalid = 1'b1; bus.s_rdata = 32'h55;
        RST_X = 1'b0;
        #1;
        chk("t6_busy_rst", 64'(busy), 64'd0);
        chk("t6_err_rst", 64'(err), 64'd0);
        chk("t6_outs_rst", 64'({bus.s_req, bus.m0_ack, bus.m1_ack, bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        chk("t6_rdata_rst", 64'(bus.m0_rdata), 64'd0);
        @(negedge CLK);
        chk("t6_err_held", 64'(err), 64'd0);
        @(posedge CLK); #1;
        RST_X = 1'b1;
        @(posedge CLK); #1;
        chk("t6_err_unsolicited", 64'(err), 64'd1);
        bus.s_rvalid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t6_busy_after", 64'(busy), 64'd0);

        chk("ack_queue_drained", 64'(exp_ack.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single DRAM slave port between two requesters: M0 is the UART program loader and M1 is the CPU data/MMIO-filtered memory port.
- Uses round-robin arbitration with at most one outstanding transaction.
- Routes read data back to the owning master.
- A watchdog terminates reads the DRAM never answers, so a hung controller shows up as a flagged error rather than a silent pipeline stall.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- TIMEOUT, 1024, maximum cycles to wait for s_rvalid after read acceptance; legal range 2..65535.
- BAD_DATA, 32'hDEADDEAD, read data returned on timeout.

Ports:
- CLK  in  1  clock.
- RST_X  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1  request; held stable with all fields until the matching ack.
- m0_we, m1_we  in  DW/8  byte write enables; 0 means read.
- m0_addr, m1_addr  in  AW  byte address, passed through unmodified.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_ack, m1_ack  out  1  request accepted by the slave; single-cycle pulse.
- m0_rvalid, m1_rvalid  out  1  read data valid; single-cycle pulse.
- m0_rdata, m1_rdata  out  DW  read data; valid only with the matching rvalid.
- s_req  out  1  request to DRAM.
- s_we  out  DW/8  byte enables.
- s_addr  out  AW  address.
- s_wdata  out  DW  write data.
- s_ready  in  1  slave accepts when s_req && s_ready.
- s_rvalid  in  1  slave read data valid.
- s_rdata  in  DW  slave read data.
- err  out  1  sticky error flag: timeout or unsolicited s_rvalid.
- busy  out  1  state != IDLE.

Behaviour:
Reset (RST_X low, asynchronous):
- state = IDLE, grant = 0, last = 1, timeout counter = 0, err = 0.
- All outputs are 0.
- Reset mid-transaction abandons the transaction; no ack or rvalid is issued afterwards.

FSM, registered state, three states:
- IDLE
  - If exactly one req is high, grant that master.
  - If both are high, grant = ~last.
  - Then go to ISSUE. If neither is high, stay in IDLE.
  - The grant decision is registered: req seen in cycle N gives s_req high in cycle N+1.
- ISSUE
  - s_req = 1; s_we, s_addr and s_wdata are muxed combinationally from the granted master's live inputs.
  - When s_ready is high: pulse mgrant_ack in the same cycle and set last = grant.
    - If s_we != 0, go to IDLE.
    - Otherwise go to WAIT_RD and clear the counter.
  - If the granted req drops before s_ready (protocol violation): return to IDLE, no ack, err unchanged.
- WAIT_RD
  - s_req = 0; the counter increments every cycle.
  - If s_rvalid is high: mgrant_rvalid = 1 and mgrant_rdata = s_rdata, both combinational from the slave; go to IDLE.
  - Otherwise, if the counter == TIMEOUT-1: mgrant_rvalid = 1, mgrant_rdata = BAD_DATA, err <= 1; go to IDLE.
  - s_rvalid in the same cycle as the counter reaching TIMEOUT-1 takes priority: it is a normal completion and err is not set.

Other rules:
- Non-granted masters always see ack = 0 and rvalid = 0; their rdata is 0.
- s_rvalid while in IDLE or ISSUE is unsolicited: err <= 1, data dropped.
- err clears only on reset.
- Throughput: writes take a minimum of 2 cycles each, because IDLE is always visited between transactions.
- Fairness: with both masters continuously requesting, grants alternate M0, M1, M0, …; neither master waits more than one transaction.
- A master with req high during another master's transaction is granted at the next IDLE.

Test Plan:
- Reset, then a single M1 write: m1_req=1, we=4'hF, addr=32'h100, wdata=32'h12345678, s_ready tied high → s_req high in cycle 2, m1_ack pulses in cycle 2, s_addr=32'h100, busy drops in cycle 3, err=0.
- Simultaneous requests: M0 and M1 both raise req in the same cycle straight after reset → M0 is granted first (last=1), M1 second; repeating 4 times gives the grant order 0,1,0,1,0,1,0,1.
- Read with latency: M0 read addr=32'h40, s_ready high, s_rvalid 5 cycles after acceptance with s_rdata=32'hCAFEF00D → m0_rvalid pulses once with 32'hCAFEF00D, m1_rvalid stays 0, err=0.
- Timeout: TIMEOUT=8, M1 read, s_rvalid never asserted → m1_rvalid in the 8th WAIT_RD cycle with rdata=32'hDEADDEAD, err=1. A late s_rvalid afterwards leaves err=1 and produces no rvalid.
- Backpressure: s_ready held low for 10 cycles during an M0 write → s_req and s_addr are stable for all 10 cycles, a pending M1 req is not granted, m0_ack occurs only on the s_ready cycle.
- Reset mid-read: RST_X pulled low in WAIT_RD → all outputs are 0 immediately (asynchronous). After release, state=IDLE, a subsequent s_rvalid sets err=1, and no m*_rvalid is produced.
